// File: rtl/player_bullet_pool_if.sv
// Bundle of game-control inputs and renderer/FSM outputs for the player bullet pool.
// The master drives requests and positions; the slave (the pool) returns bullet state and events.
interface player_bullet_pool_if #(
   parameter int N_SLOTS = 4
);
   localparam int HCW = $clog2(N_SLOTS + 1);

   logic                      tick;
   logic                      clear;
   logic                      attack;
   logic                      defend;
   logic signed [10:0]        xPlayer;
   logic signed [9:0]         yPlayer;
   logic signed [10:0]        xEnemy;
   logic signed [9:0]         yEnemy;
   logic                      enemyQ;
   logic [11*N_SLOTS-1:0]     x_flat;
   logic [10*N_SLOTS-1:0]     y_flat;
   logic [N_SLOTS-1:0]        alive;
   logic                      fired;
   logic                      fire_drop;
   logic                      hit;
   logic [HCW-1:0]            hit_count;

   modport master (
      output tick, clear, attack, defend, xPlayer, yPlayer, xEnemy, yEnemy, enemyQ,
      input  x_flat, y_flat, alive, fired, fire_drop, hit, hit_count
   );

   modport slave (
      input  tick, clear, attack, defend, xPlayer, yPlayer, xEnemy, yEnemy, enemyQ,
      output x_flat, y_flat, alive, fired, fire_drop, hit, hit_count
   );
endinterface

// File: rtl/player_bullet_pool.sv
// Pool of rightward-travelling player bullets: cooldown-gated firing, per-tick motion,
// and enemy hitbox detection (standing or squatting); all outputs registered.
module player_bullet_pool #(
   parameter int N_SLOTS        = 4,
   parameter int COOLDOWN_TICKS = 16,
   parameter int STEP_X         = 8,
   parameter int BULLET_X       = 4,
   parameter int BULLET_Y       = 4,
   parameter int PLAYER_X       = 16,
   parameter int PLAYER_Y       = 32,
   parameter int SQUAT_Y        = 16,
   parameter int MAP_X          = 320
) (
   input  logic                 clk,
   input  logic                 rst,
   player_bullet_pool_if.slave  bus
);
   localparam int HCW = $clog2(N_SLOTS + 1);
   localparam int CDW = $clog2(COOLDOWN_TICKS + 1);

   localparam logic signed [12:0] C_STEP  = 13'(STEP_X);
   localparam logic signed [12:0] C_BX    = 13'(BULLET_X);
   localparam logic signed [12:0] C_PX    = 13'(PLAYER_X);
   localparam logic signed [12:0] C_XLIM  = 13'(MAP_X - BULLET_X);
   localparam logic signed [11:0] C_BY    = 12'(BULLET_Y);
   localparam logic signed [11:0] C_PY    = 12'(PLAYER_Y);
   localparam logic signed [11:0] C_SY    = 12'(SQUAT_Y);

   logic signed [10:0]  r_x [N_SLOTS];
   logic signed [9:0]   r_y [N_SLOTS];
   logic [N_SLOTS-1:0]  r_alive;
   logic [CDW-1:0]      r_cd;
   logic                r_fired;
   logic                r_fire_drop;
   logic [HCW-1:0]      r_hit_count;

   logic signed [12:0]  w_nx [N_SLOTS];
   logic [N_SLOTS-1:0]  w_hit;
   logic [N_SLOTS-1:0]  w_exit;
   logic [N_SLOTS-1:0]  w_alloc;
   logic [N_SLOTS-1:0]  w_alive_nxt;
   logic [CDW-1:0]      w_cd_nxt;
   logic [HCW-1:0]      w_hit_cnt;
   logic                w_free_seen;
   logic                w_fire_ok;
   logic signed [12:0]  w_xe;
   logic signed [11:0]  w_ye;
   logic signed [11:0]  w_hy;
   logic signed [12:0]  w_newx;

   assign w_xe      = {{2{bus.xEnemy[10]}}, bus.xEnemy};
   assign w_ye      = {{2{bus.yEnemy[9]}}, bus.yEnemy};
   assign w_hy      = bus.enemyQ ? C_SY : C_PY;
   assign w_newx    = {{2{bus.xPlayer[10]}}, bus.xPlayer} + C_PX + C_BX;
   assign w_fire_ok = bus.attack && !bus.defend && (r_cd == '0);

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      logic signed [12:0] w_xs;
      logic signed [11:0] w_ys;
      logic [1:0]         w_unused_nx_hi;

      assign w_xs    = {{2{r_x[g][10]}}, r_x[g]};
      assign w_ys    = {{2{r_y[g][9]}}, r_y[g]};
      assign w_nx[g] = w_xs + C_STEP;
      // Vertical test is written as "not separated" so touching edges still count as a hit.
      assign w_hit[g] = r_alive[g]
                     && (w_nx[g] + C_BX > w_xe - C_PX)
                     && (w_nx[g] - C_BX < w_xe + C_PX)
                     && !(w_ys - C_BY > w_ye + w_hy)
                     && !(w_ys + C_BY < w_ye - w_hy);
      assign w_exit[g] = w_nx[g] > C_XLIM;
      assign w_unused_nx_hi = w_nx[g][12:11];

      assign bus.x_flat[11*g +: 11] = r_x[g];
      assign bus.y_flat[10*g +: 10] = r_y[g];
   end

   logic [1:0] w_unused_newx_hi;
   assign w_unused_newx_hi = w_newx[12:11];

   // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
   always_comb begin
      w_alive_nxt = r_alive;
      w_cd_nxt    = r_cd;
      w_hit_cnt   = '0;
      w_alloc     = '0;
      w_free_seen = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (w_hit[i]) begin
            w_alive_nxt[i] = 1'b0;
            w_hit_cnt      = w_hit_cnt + HCW'(1);
         end else if (r_alive[i] && w_exit[i]) begin
            w_alive_nxt[i] = 1'b0;
         end
         // Free-slot search looks at start-of-tick occupancy, so slots freed this tick wait.
         if (!r_alive[i] && !w_free_seen) begin
            w_alloc[i]  = w_fire_ok;
            w_free_seen = 1'b1;
         end
      end
      if (r_cd != '0)
         w_cd_nxt = r_cd - CDW'(1);
      if (w_fire_ok && w_free_seen)
         w_cd_nxt = CDW'(COOLDOWN_TICKS);
      w_alive_nxt = w_alive_nxt | w_alloc;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the position arrays are reset too, because renderers read x/y of dead slots.
         for (int i = 0; i < N_SLOTS; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
         end
         r_alive     <= '0;
         r_cd        <= '0;
         r_fired     <= 1'b0;
         r_fire_drop <= 1'b0;
         r_hit_count <= '0;
      end else if (bus.clear) begin
         r_alive     <= '0;
         r_cd        <= '0;
         r_fired     <= 1'b0;
         r_fire_drop <= 1'b0;
         r_hit_count <= '0;
      end else if (bus.tick) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            if (w_alloc[i]) begin
               r_x[i] <= w_newx[10:0];
               r_y[i] <= bus.yPlayer;
            end else if (r_alive[i] && !w_hit[i] && !w_exit[i]) begin
               r_x[i] <= w_nx[i][10:0];
            end
         end
         r_alive     <= w_alive_nxt;
         r_cd        <= w_cd_nxt;
         r_fired     <= w_fire_ok && w_free_seen;
         r_fire_drop <= w_fire_ok && !w_free_seen;
         r_hit_count <= w_hit_cnt;
      end else begin
         r_fired     <= 1'b0;
         r_fire_drop <= 1'b0;
         r_hit_count <= '0;
      end
   end

   assign bus.alive     = r_alive;
   assign bus.fired     = r_fired;
   assign bus.fire_drop = r_fire_drop;
   assign bus.hit_count = r_hit_count;
   assign bus.hit       = (r_hit_count != '0);
endmodule

// File: tb/tb_player_bullet_pool.sv
// Two pools (cooldown 16 and cooldown 1) share one stimulus stream and are compared every
// cycle against an integer reference model, plus directed checks from the game scenarios.
module tb_player_bullet_pool;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_r = 1'b1;
   logic        tick_r = 1'b0, clear_r = 1'b0, attack_r = 1'b0, defend_r = 1'b0, enemyq_r = 1'b0;
   int          xp = 0, yp = 0, xe = 0, ye = 0;

   int n_cmp = 0;
   int n_err = 0;

   player_bullet_pool_if #(.N_SLOTS(N)) if0 ();
   player_bullet_pool_if #(.N_SLOTS(N)) if1 ();

   assign if0.tick = tick_r;     assign if1.tick = tick_r;
   assign if0.clear = clear_r;   assign if1.clear = clear_r;
   assign if0.attack = attack_r; assign if1.attack = attack_r;
   assign if0.defend = defend_r; assign if1.defend = defend_r;
   assign if0.enemyQ = enemyq_r; assign if1.enemyQ = enemyq_r;
   assign if0.xPlayer = 11'(xp); assign if1.xPlayer = 11'(xp);
   assign if0.yPlayer = 10'(yp); assign if1.yPlayer = 10'(yp);
   assign if0.xEnemy = 11'(xe);  assign if1.xEnemy = 11'(xe);
   assign if0.yEnemy = 10'(ye);  assign if1.yEnemy = 10'(ye);

   player_bullet_pool #(.N_SLOTS(N), .COOLDOWN_TICKS(16)) u_dut0 (.clk(clk), .rst(rst_r), .bus(if0.slave));
   player_bullet_pool #(.N_SLOTS(N), .COOLDOWN_TICKS(1))  u_dut1 (.clk(clk), .rst(rst_r), .bus(if1.slave));

   // Reference model state, one copy per DUT.
   int mx [2][N];
   int my [2][N];
   bit mal [2][N];
   int mcd [2];
   bit mfired [2];
   bit mdrop [2];
   int mhc [2];
   int cdmax [2] = '{16, 1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input int m);
      int free, hc, nx, hy;
      bit elig;
      if (rst_r) begin
         for (int i = 0; i < N; i++) begin mx[m][i] = 0; my[m][i] = 0; mal[m][i] = 0; end
         mcd[m] = 0; mfired[m] = 0; mdrop[m] = 0; mhc[m] = 0;
      end else if (clear_r) begin
         for (int i = 0; i < N; i++) mal[m][i] = 0;
         mcd[m] = 0; mfired[m] = 0; mdrop[m] = 0; mhc[m] = 0;
      end else if (tick_r) begin
         free = -1;
         for (int i = 0; i < N; i++) if (!mal[m][i] && free < 0) free = i;
         hc = 0;
         hy = enemyq_r ? 16 : 32;
         for (int i = 0; i < N; i++) begin
            if (mal[m][i]) begin
               nx = mx[m][i] + 8;
               if (nx + 4 > xe - 16 && nx - 4 < xe + 16 &&
                   !(my[m][i] - 4 > ye + hy) && !(my[m][i] + 4 < ye - hy)) begin
                  mal[m][i] = 0;
                  hc++;
               end else if (nx > 316) begin
                  mal[m][i] = 0;
               end else begin
                  mx[m][i] = nx;
               end
            end
         end
         elig = attack_r && !defend_r && mcd[m] == 0;
         if (mcd[m] > 0) mcd[m]--;
         mfired[m] = 0;
         mdrop[m]  = 0;
         if (elig) begin
            if (free >= 0) begin
               mal[m][free] = 1; mx[m][free] = xp + 20; my[m][free] = yp;
               mcd[m] = cdmax[m]; mfired[m] = 1;
            end else begin
               mdrop[m] = 1;
            end
         end
         mhc[m] = hc;
      end else begin
         mfired[m] = 0; mdrop[m] = 0; mhc[m] = 0;
      end
   endtask

   task automatic compare_dut(input int m, input logic [N-1:0] al, input logic [11*N-1:0] xf,
                              input logic [10*N-1:0] yf, input logic fi, input logic fd,
                              input logic h, input logic [2:0] hc);
      logic [N-1:0]    e_al;
      logic [11*N-1:0] e_x;
      logic [10*N-1:0] e_y;
      for (int i = 0; i < N; i++) begin
         e_al[i]         = mal[m][i];
         e_x[11*i +: 11] = 11'(mx[m][i]);
         e_y[10*i +: 10] = 10'(my[m][i]);
      end
      check($sformatf("d%0d_alive", m), 64'(al), 64'(e_al));
      check($sformatf("d%0d_x_flat", m), 64'(xf), 64'(e_x));
      check($sformatf("d%0d_y_flat", m), 64'(yf), 64'(e_y));
      check($sformatf("d%0d_fired", m), 64'(fi), 64'(mfired[m]));
      check($sformatf("d%0d_fire_drop", m), 64'(fd), 64'(mdrop[m]));
      check($sformatf("d%0d_hit", m), 64'(h), 64'(mhc[m] != 0));
      check($sformatf("d%0d_hit_count", m), 64'(hc), 64'(mhc[m]));
   endtask

   task automatic step(input bit t, input bit c);
      tick_r  = t;
      clear_r = c;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare_dut(0, if0.alive, if0.x_flat, if0.y_flat, if0.fired, if0.fire_drop, if0.hit, if0.hit_count);
      compare_dut(1, if1.alive, if1.x_flat, if1.y_flat, if1.fired, if1.fire_drop, if1.hit, if1.hit_count);
      tick_r  = 1'b0;
      clear_r = 1'b0;
   endtask

   task automatic do_reset();
      rst_r = 1'b1;
      step(1'b1, 1'b0);
      rst_r = 1'b0;
   endtask

   initial begin
      // Reset state.
      do_reset();
      check("reset_alive", 64'(if0.alive), 64'(0));

      // Fire, cooldown hold, refire, then single-bullet hit on tick 33.
      xp = -200; yp = 0; xe = 100; ye = 0; enemyq_r = 0; attack_r = 1;
      step(1, 0);
      check("t1_x0", $signed(if0.x_flat[10:0]), -180);
      check("t1_fired", 64'(if0.fired), 64'(1));
      repeat (16) step(1, 0);
      step(1, 0);
      check("t1_refire_alive", 64'(if0.alive), 64'(4'b0011));
      attack_r = 0;
      repeat (15) step(1, 0);
      step(1, 0);
      check("t2_hit", 64'(if0.hit), 64'(1));
      check("t2_hit_count", 64'(if0.hit_count), 64'(1));
      check("t2_alive0", 64'(if0.alive[0]), 64'(0));

      // Squatting enemy is missed; bullet exits at nx=324 on tick 63.
      step(1, 1);
      ye = 30; enemyq_r = 1; attack_r = 1;
      step(1, 0);
      attack_r = 0;
      repeat (62) step(1, 0);
      check("t3_alive_before_exit", 64'(if0.alive[0]), 64'(1));
      step(1, 0);
      check("t3_alive_after_exit", 64'(if0.alive[0]), 64'(0));
      check("t3_no_hit", 64'(if0.hit), 64'(0));

      // Pool full with cooldown 1: fills on ticks 0,2,4,6, drops on tick 8.
      step(1, 1);
      ye = 300; enemyq_r = 0; attack_r = 1;
      repeat (8) step(1, 0);
      step(1, 0);
      check("t4_drop", 64'(if1.fire_drop), 64'(1));
      check("t4_full", 64'(if1.alive), 64'(4'b1111));

      // Two bullets with equal x hit together.
      step(1, 1);
      ye = 0; xp = -200; attack_r = 1;
      step(1, 0);
      attack_r = 0;
      repeat (16) step(1, 0);
      xp = -64; attack_r = 1;
      step(1, 0);
      attack_r = 0;
      repeat (15) step(1, 0);
      step(1, 0);
      check("t5_hit_count", 64'(if0.hit_count), 64'(2));
      check("t5_alive", 64'(if0.alive[1:0]), 64'(0));

      // clear with tick while three bullets live and cooldown=5, then reset mid-flight.
      step(1, 1);
      xp = -200; ye = 300;
      for (int k = 0; k < 3; k++) begin
         attack_r = 1;
         step(1, 0);
         attack_r = 0;
         if (k < 2) repeat (16) step(1, 0);
      end
      repeat (11) step(1, 0);
      attack_r = 1;
      step(1, 1);
      check("t6_clear_alive", 64'(if0.alive), 64'(0));
      check("t6_clear_fired", 64'(if0.fired), 64'(0));
      step(1, 0);
      check("t6_fire_after_clear", 64'(if0.fired), 64'(1));
      repeat (3) step(1, 0);
      do_reset();
      check("t6_rst_x", 64'(if0.x_flat), 64'(0));

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         attack_r = 1'($urandom_range(0, 3) != 0);
         defend_r = 1'($urandom_range(0, 7) == 0);
         enemyq_r = 1'($urandom_range(0, 1));
         xp = int'($urandom_range(0, 600)) - 320;
         yp = int'($urandom_range(0, 120)) - 60;
         xe = int'($urandom_range(0, 640)) - 320;
         ye = int'($urandom_range(0, 120)) - 60;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
